// File: rtl/vram_writer_pkg.sv
// Shared VRAM bus widths and writer FSM encoding; also used by the GPU and RAM model.
package vram_writer_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/vram_writer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/count come straight from
// the registered pointers, so a same-cycle pop never raises ready early.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             din_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o   = (wr_q == rd_q);
  assign count_o   = CW'(wr_q - rd_q);
  assign dout_o    = mem_q[rd_q[AW-1:0]];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer advance
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/vram_writer.sv
// VRAM write-side master: queues CPU write requests and commits each one with a
// SETUP / STROBE(WE_CYCLES) / HOLD cycle while the GPU grants the bus.
module vram_writer
  import vram_writer_pkg::*;
#(
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int DATA_W    = VRAM_DATA_W,
  parameter int DEPTH     = 4,
  parameter int WE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       bus_grant,
  output logic                       bus_owned,
  output logic [ADDR_W-1:0]          vram_addr,
  output logic [DATA_W-1:0]          vram_wdata,
  output logic                       vram_we,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  wr_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic                       owned_q, owned_d;
  logic                       we_q, we_d;
  logic                       pop_s;
  logic                       start_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [ADDR_W+DATA_W-1:0]   fifo_dout_s;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (req_valid),
    .pop_i   (pop_s),
    .din_i   ({req_addr, req_data}),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (pending)
  );

  assign req_ready  = !fifo_full_s;
  assign start_s    = !fifo_empty_s && bus_grant;
  assign bus_owned  = owned_q;
  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = data_q;

  // State, strobe counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      owned_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owned_q <= owned_d;
      we_q    <= we_d;
    end
  end

  // Next state; a started sequence runs to HOLD regardless of grant
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SETUP;
          pop_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          state_d = STROBE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (start_s) begin
          state_d = SETUP;
          pop_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they leave the flops cleanly
  always_comb begin
    owned_d = (state_d != IDLE);
    we_d    = (state_d == STROBE);
    if (pop_s) begin
      addr_d = fifo_dout_s[ADDR_W+DATA_W-1:DATA_W];
      data_d = fifo_dout_s[DATA_W-1:0];
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

endmodule
